spi_slave: RTL

- SPI responder (slave) that sits on the far side of the SPI bus from spi_module.
- Receives serial data on MOSI, returns a preloaded word on MISO, and hands received words to the host side in parallel with an interrupt.
- All bus inputs are oversampled in the system clock domain. There is no SCK-domain logic.

---
 rtl/spi_slave.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI responder, all bus inputs oversampled in the system clock domain.
// Optional: define SPI_SLAVE_OVR_IRQ_EN so that an overrun alone also raises o_interrupt.
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic [7:0]        i_data_config,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_load,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_data,
  output logic              o_rx_valid,
  output logic              o_tx_empty,
  output logic              o_overrun,
  output logic              o_interrupt,
  input  logic              i_SCK,
  input  logic              i_SS,
  input  logic              i_MOSI,
  output logic              o_MISO,
  output logic              o_MISO_oe
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sckSync_q, ssSync_q, mosiSync_q;
  logic                   sckPrev_q, ssPrev_q;
  logic                   cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      rxShift_q, rxShift_d, txShift_q, txShift_d;
  logic [DATA_W-1:0]      txBuf_q, txBuf_d, data_q, data_d;
  logic                   txEmpty_q, txEmpty_d, rxValid_q, rxValid_d;
  logic                   overrun_q, overrun_d, miso_q, miso_d, oe_q, oe_d;

  logic spe, spie, sckNow, ssNow, mosiNow;
  logic sckRise, sckFall, ssFall, ssRise, leadEdge, trailEdge, sampleEdge, shiftEdge;
  logic bufTaken;
  logic [DATA_W-1:0] loadWord;
  logic unusedCfg;

  function automatic logic headBit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shiftOut(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  assign spe       = i_data_config[7];
  assign spie      = i_data_config[6];
  assign unusedCfg = ^{i_data_config[5:4], i_data_config[1]};

  assign sckNow     = sckSync_q[SYNC_STAGES-1];
  assign ssNow      = ssSync_q[SYNC_STAGES-1];
  assign mosiNow    = mosiSync_q[SYNC_STAGES-1];
  assign sckRise    = sckNow & ~sckPrev_q;
  assign sckFall    = ~sckNow & sckPrev_q;
  assign ssFall     = ~ssNow & ssPrev_q;
  assign ssRise     = ssNow & ~ssPrev_q;
  assign leadEdge   = cpol_q ? sckFall : sckRise;
  assign trailEdge  = cpol_q ? sckRise : sckFall;
  assign sampleEdge = cpha_q ? trailEdge : leadEdge;
  assign shiftEdge  = cpha_q ? leadEdge : trailEdge;

  // An empty buffer sends zeros unless the host writes in the very cycle it is taken.
  assign loadWord = txEmpty_q ? (i_load ? i_data : '0) : txBuf_q;

  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    cnt_d     = cnt_q;
    rxShift_d = rxShift_q;
    txShift_d = txShift_q;
    txBuf_d   = txBuf_q;
    txEmpty_d = txEmpty_q;
    data_d    = data_q;
    rxValid_d = rxValid_q;
    overrun_d = overrun_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    bufTaken  = 1'b0;

    if (i_rd) begin
      rxValid_d = 1'b0;
      overrun_d = 1'b0;
    end

    if (!spe) begin
      state_d = IDLE;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ssNow) oe_d = 1'b0;
          if (ssFall) begin
            state_d = LOAD;
            cpol_d  = i_data_config[3];
            cpha_d  = i_data_config[2];
            lsb_d   = i_data_config[0];
          end
        end
        LOAD: begin
          if (ssRise) begin
            state_d = IDLE;
            oe_d    = 1'b0;
          end else begin
            bufTaken  = 1'b1;
            oe_d      = 1'b1;
            cnt_d     = '0;
            state_d   = SHIFT;
            if (cpha_q) begin
              txShift_d = loadWord;
            end else begin
              miso_d    = headBit(loadWord, lsb_q);
              txShift_d = shiftOut(loadWord, lsb_q);
            end
          end
        end
        SHIFT: begin
          if (ssRise) begin
            state_d = IDLE;
            oe_d    = 1'b0;
          end else begin
            if (shiftEdge) begin
              miso_d    = headBit(txShift_q, lsb_q);
              txShift_d = shiftOut(txShift_q, lsb_q);
            end
            if (sampleEdge) begin
              rxShift_d = lsb_q ? {mosiNow, rxShift_q[DATA_W-1:1]}
                                : {rxShift_q[DATA_W-2:0], mosiNow};
              if (cnt_q == CNT_W'(DATA_W - 1)) begin
                cnt_d   = '0;
                state_d = DONE;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (!rxValid_q || i_rd) begin
            data_d    = rxShift_q;
            rxValid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
          // Back-to-back: the next word's first bit goes out on the next shift edge,
          // which for CPHA=0 is the trailing edge of the frame just finished.
          if (!ssNow) begin
            state_d   = SHIFT;
            bufTaken  = 1'b1;
            txShift_d = loadWord;
            cnt_d     = '0;
            oe_d      = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      endcase
    end

    if (bufTaken) begin
      txEmpty_d = 1'b1;
    end else if (i_load && txEmpty_q) begin
      txBuf_d   = i_data;
      txEmpty_d = 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      state_q    <= IDLE;
      sckSync_q  <= {SYNC_STAGES{i_data_config[3]}};
      sckPrev_q  <= i_data_config[3];
      ssSync_q   <= '1;
      ssPrev_q   <= 1'b1;
      mosiSync_q <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      cnt_q      <= '0;
      rxShift_q  <= '0;
      txShift_q  <= '0;
      txBuf_q    <= '0;
      txEmpty_q  <= 1'b1;
      data_q     <= '0;
      rxValid_q  <= 1'b0;
      overrun_q  <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sckSync_q  <= {sckSync_q[SYNC_STAGES-2:0], i_SCK};
      sckPrev_q  <= sckNow;
      ssSync_q   <= {ssSync_q[SYNC_STAGES-2:0], i_SS};
      ssPrev_q   <= ssNow;
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], i_MOSI};
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      cnt_q      <= cnt_d;
      rxShift_q  <= rxShift_d;
      txShift_q  <= txShift_d;
      txBuf_q    <= txBuf_d;
      txEmpty_q  <= txEmpty_d;
      data_q     <= data_d;
      rxValid_q  <= rxValid_d;
      overrun_q  <= overrun_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
    end
  end

  assign o_data     = data_q;
  assign o_rx_valid = rxValid_q;
  assign o_tx_empty = txEmpty_q;
  assign o_overrun  = overrun_q;
  assign o_MISO     = miso_q;
  assign o_MISO_oe  = oe_q;

`ifdef SPI_SLAVE_OVR_IRQ_EN
  assign o_interrupt = spie & (rxValid_q | overrun_q);
`else
  assign o_interrupt = spie & rxValid_q;
`endif

endmodule
